// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB packet transmitter.
// Serialises SYNC, PID, payload, CRC16 and EOP onto D+/D-. The line is
// NRZI-encoded and bit-stuffed. Each bus bit lasts CLKS_PER_BIT clocks.
// The pad outputs are registered one cycle behind the internal bit state.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC,
        S_EOP
    } state_t;

    // PID nibble for each request code; 0 marks an invalid code.
    function automatic logic [3:0] pid_of(input logic [2:0] code);
        case (code)
            3'd1:    pid_of = 4'h3;  // DATA0
            3'd2:    pid_of = 4'hB;  // DATA1
            3'd3:    pid_of = 4'h2;  // ACK
            3'd4:    pid_of = 4'hA;  // NAK
            3'd5:    pid_of = 4'hE;  // STALL
            default: pid_of = 4'h0;
        endcase
    endfunction

    // CRC16 (poly 0x8005) is computed in bit-reversed form (0xA001).
    // Bit 0 of the register therefore becomes the first CRC bit sent.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        crc_step = {1'b0, crc[15:1]} ^ (((crc[0] ^ b) == 1'b1) ? 16'hA001 : 16'h0000);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   crc_q, crc_d;
    logic [2:0]    ones_q, ones_d;
    logic [6:0]    bytes_q, bytes_d;
    logic [3:0]    pid_q, pid_d;
    logic          line_q, line_d;
    logic [1:0]    eop_q, eop_d;
    logic          err_q, err_d;
    logic          dplus_q, dplus_d;
    logic          dminus_q, dminus_d;
    logic          active_q, active_d;

    logic bit_end, is_data, se0, load_byte;
    logic emit_en, emit_bit, emit_cnt, emit_crc, go_load, go_crc;

    assign is_data = (pid_q == 4'h3) || (pid_q == 4'hB);

    // Next-state logic: bit timing, field sequencing, stuffing, NRZI and CRC.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        ones_d    = ones_q;
        bytes_d   = bytes_q;
        pid_d     = pid_q;
        line_d    = line_q;
        eop_d     = eop_q;
        err_d     = 1'b0;
        load_byte = 1'b0;
        emit_en   = 1'b0;
        emit_bit  = 1'b0;
        emit_cnt  = 1'b0;
        emit_crc  = 1'b0;
        go_load   = 1'b0;
        go_crc    = 1'b0;
        bit_end   = (cnt_q == CNT_LAST);

        if (state_q == S_IDLE) begin
            line_d = 1'b1;
            if (start) begin
                if (pid_of(tx_packet) != 4'h0) begin
                    pid_d    = pid_of(tx_packet);
                    bytes_d  = buffer_occupancy;
                    state_d  = S_SYNC;
                    cnt_d    = '0;
                    bit_d    = '0;
                    crc_d    = 16'hFFFF;
                    ones_d   = '0;
                    emit_en  = 1'b1;   // first SYNC bit is a 0
                    emit_bit = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if ((state_q inside {S_PID, S_DATA, S_CRC}) && (ones_q == 3'd6)) begin
                // Stuffed zero: the field position does not advance.
                emit_en  = 1'b1;
                emit_bit = 1'b0;
                emit_cnt = 1'b1;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        emit_en = 1'b1;
                        if (bit_q == 4'd7) begin
                            state_d  = S_PID;
                            bit_d    = '0;
                            shift_d  = {~pid_q, pid_q};
                            emit_bit = pid_q[0];
                            emit_cnt = 1'b1;
                        end else begin
                            bit_d    = bit_q + 4'd1;
                            emit_bit = (bit_q == 4'd6);
                        end
                    end
                    S_PID: begin
                        if (bit_q == 4'd7) begin
                            if (!is_data) begin
                                state_d = S_EOP;
                                eop_d   = 2'd0;
                            end else if (bytes_q == 7'd0) begin
                                go_crc = 1'b1;
                            end else begin
                                go_load = 1'b1;
                            end
                        end else begin
                            bit_d    = bit_q + 4'd1;
                            shift_d  = {1'b0, shift_q[7:1]};
                            emit_en  = 1'b1;
                            emit_bit = shift_q[1];
                            emit_cnt = 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_q == 4'd7) begin
                            if (bytes_q != 7'd0) go_load = 1'b1;
                            else                 go_crc  = 1'b1;
                        end else begin
                            bit_d    = bit_q + 4'd1;
                            shift_d  = {1'b0, shift_q[7:1]};
                            emit_en  = 1'b1;
                            emit_bit = shift_q[1];
                            emit_cnt = 1'b1;
                            emit_crc = 1'b1;
                        end
                    end
                    S_CRC: begin
                        if (bit_q == 4'd15) begin
                            state_d = S_EOP;
                            eop_d   = 2'd0;
                        end else begin
                            bit_d    = bit_q + 4'd1;
                            crc_d    = {1'b0, crc_q[15:1]};
                            emit_en  = 1'b1;
                            emit_bit = ~crc_q[1];
                            emit_cnt = 1'b1;
                        end
                    end
                    S_EOP: begin
                        if (eop_q == 2'd2) begin
                            state_d = S_IDLE;
                        end else begin
                            eop_d = eop_q + 2'd1;
                            if (eop_q == 2'd1) line_d = 1'b1;  // J after the two SE0 bits
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Pop the buffer head into the shift register and start its first bit.
        if (go_load) begin
            state_d   = S_DATA;
            bit_d     = '0;
            shift_d   = tx_packet_data;
            bytes_d   = bytes_q - 7'd1;
            load_byte = 1'b1;
            emit_en   = 1'b1;
            emit_bit  = tx_packet_data[0];
            emit_cnt  = 1'b1;
            emit_crc  = 1'b1;
        end

        // Start the complemented CRC. The register already holds every payload bit.
        if (go_crc) begin
            state_d  = S_CRC;
            bit_d    = '0;
            emit_en  = 1'b1;
            emit_bit = ~crc_q[0];
            emit_cnt = 1'b1;
        end

        // NRZI: a 0 toggles the line and a 1 holds it. Track the run of 1s for stuffing.
        if (emit_en) begin
            line_d = emit_bit ? line_q : ~line_q;
            if (emit_cnt) ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
            if (emit_crc) crc_d = crc_step(crc_q, emit_bit);
        end

        se0      = (state_q == S_EOP) && (eop_q != 2'd2);
        dplus_d  = ~se0 & line_q;
        dminus_d = ~se0 & ~line_q;
        active_d = (state_q != S_IDLE);
    end

    // State and output registers; reset puts the bus at J immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            crc_q    <= 16'hFFFF;
            ones_q   <= '0;
            bytes_q  <= '0;
            pid_q    <= '0;
            line_q   <= 1'b1;
            eop_q    <= '0;
            err_q    <= 1'b0;
            dplus_q  <= 1'b1;
            dminus_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all flops update together at the edge.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            ones_q   <= ones_d;
            bytes_q  <= bytes_d;
            pid_q    <= pid_d;
            line_q   <= line_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
            dplus_q  <= dplus_d;
            dminus_q <= dminus_d;
            active_q <= active_d;
        end
    end

    assign get_tx_packet_data = load_byte;
    assign dplus_out          = dplus_q;
    assign dminus_out         = dminus_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder. Stimulus pushes one expected bus
// symbol per clock; per-DUT monitors pop and compare while the DUT is active.
module tb_usb_tx_encoder;

    localparam logic [1:0] J  = 2'b10;
    localparam logic [1:0] K  = 2'b01;
    localparam logic [1:0] S0 = 2'b00;

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    logic       clk, rst, start4, start8;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get4, dp4, dm4, act4, err4;
    logic       get8, dp8, dm8, act8, err8;

    logic [7:0] buf_mem [0:63];
    int         rd_ptr;

    exp_t q4[$];
    exp_t q8[$];
    int   exp_gets4;
    int   gets4, gets8;
    bit   idle4, idle8, mon_off4;
    int   n_checks, n_pass;

    usb_tx_encoder #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .tx_packet(tx_packet),
        .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data),
        .get_tx_packet_data(get4), .dplus_out(dp4), .dminus_out(dm4),
        .tx_transfer_active(act4), .tx_error(err4)
    );

    usb_tx_encoder #(.CLKS_PER_BIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .tx_packet(tx_packet),
        .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data),
        .get_tx_packet_data(get8), .dplus_out(dp8), .dminus_out(dm8),
        .tx_transfer_active(act8), .tx_error(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: the head byte is visible combinationally, and a get pulse pops it.
    assign tx_packet_data = buf_mem[rd_ptr % 64];
    always @(posedge clk or posedge rst) begin
        if (rst)       rd_ptr <= 0;
        else if (get4) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Push one bus bit: cpb copies of the symbol, with the last-flag on the final copy.
    task automatic emit(input bit sel8, input logic [1:0] s, input bit last);
        int cpb;
        exp_t e;
        cpb = sel8 ? 8 : 4;
        for (int i = 0; i < cpb; i++) begin
            e.sym  = s;
            e.last = last && (i == cpb - 1);
            if (sel8) q8.push_back(e);
            else      q4.push_back(e);
        end
    endtask

    // ACK packet levels, worked out by hand: SYNC, then NRZI of D2, then EOP.
    task automatic push_ack_table(input bit sel8);
        logic [1:0] tbl [19];
        tbl = '{K, J, K, J, K, J, K, K,  J, J, K, J, J, K, K, K,  S0, S0, J};
        for (int i = 0; i < 19; i++) emit(sel8, tbl[i], i == 18);
    endtask

    // Reference model for a packet on dut4. The CRC uses the MSB-first 0x8005 form.
    task automatic push_model(input logic [7:0] pid_byte, input bit has_data, input int n);
        logic       lvl;
        logic [15:0] c;
        logic [7:0] d;
        logic       fb;
        bit         bits[$];
        int         ones;
        lvl = 1'b1; c = 16'hFFFF; ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (i != 7) lvl = ~lvl;
            emit(0, lvl ? J : K, 0);
        end
        for (int i = 0; i < 8; i++) bits.push_back(pid_byte[i]);
        if (has_data) begin
            for (int k = 0; k < n; k++) begin
                d = buf_mem[(rd_ptr + k) % 64];
                for (int i = 0; i < 8; i++) begin
                    bits.push_back(d[i]);
                    fb = d[i] ^ c[15];
                    c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            end
            for (int i = 15; i >= 0; i--) bits.push_back(~c[i]);
        end
        foreach (bits[j]) begin
            if (!bits[j]) lvl = ~lvl;
            emit(0, lvl ? J : K, 0);
            ones = bits[j] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                emit(0, lvl ? J : K, 0);
                ones = 0;
            end
        end
        emit(0, S0, 0);
        emit(0, S0, 0);
        emit(0, J, 1);
    endtask

    task automatic send(input bit sel8, input logic [2:0] code, input logic [6:0] occ);
        @(negedge clk);
        tx_packet        = code;
        buffer_occupancy = occ;
        if (sel8) start8 = 1'b1;
        else      start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit sel8, input int budget);
        int i;
        i = 0;
        while (((sel8 ? q8.size() : q4.size()) != 0 || (sel8 ? idle8 : idle4)) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(sel8 ? "done8_timeout" : "done4_timeout", sel8 ? q8.size() : q4.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Monitor for dut4.
    always @(negedge clk) begin
        exp_t e;
        if (rst || mon_off4) begin
            gets4 = 0;
            idle4 = 1'b0;
        end else begin
            if (get4) gets4++;
            if (idle4) begin
                check("active_len4", act4, 1'b0);
                idle4 = 1'b0;
            end else if (act4) begin
                if (q4.size() == 0) check("extra_active4", act4, 1'b0);
                else begin
                    e = q4.pop_front();
                    check("bus4", {dp4, dm4}, e.sym);
                    if (e.last) begin
                        check("gets4", gets4, exp_gets4);
                        gets4 = 0;
                        idle4 = 1'b1;
                    end
                end
            end else if (get4) begin
                check("get_idle4", get4, 1'b0);
            end
        end
    end

    // Monitor for dut8.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gets8 = 0;
            idle8 = 1'b0;
        end else begin
            if (get8) gets8++;
            if (idle8) begin
                check("active_len8", act8, 1'b0);
                idle8 = 1'b0;
            end else if (act8) begin
                if (q8.size() == 0) check("extra_active8", act8, 1'b0);
                else begin
                    e = q8.pop_front();
                    check("bus8", {dp8, dm8}, e.sym);
                    if (e.last) begin
                        check("gets8", gets8, 0);
                        gets8 = 0;
                        idle8 = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; mon_off4 = 1'b0; exp_gets4 = 0;
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
        tx_packet = 3'd0; buffer_occupancy = 7'd0;
        for (int i = 0; i < 64; i++) buf_mem[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_dp4", dp4, 1'b1);
        check("rst_dm4", dm4, 1'b0);
        check("rst_act4", act4, 1'b0);
        check("rst_get4", get4, 1'b0);
        check("rst_err4", err4, 1'b0);
        check("rst_bus8", {dp8, dm8, act8, err8}, 4'b1000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK, with a start pulse mid-packet that must be ignored.
        exp_gets4 = 0;
        push_ack_table(0);
        send(0, 3'd3, 7'd0);
        repeat (20) @(negedge clk);
        tx_packet = 3'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(0, 400);

        // DATA0 with no payload: the CRC is all zeros.
        exp_gets4 = 0;
        push_model(8'hC3, 1, 0);
        send(0, 3'd1, 7'd0);
        wait_done(0, 800);

        // DATA1 with FF FF: long runs of 1s force bit stuffing.
        buf_mem[(rd_ptr + 0) % 64] = 8'hFF;
        buf_mem[(rd_ptr + 1) % 64] = 8'hFF;
        exp_gets4 = 2;
        push_model(8'h4B, 1, 2);
        send(0, 3'd2, 7'd2);
        wait_done(0, 1200);

        // DATA0 with three mixed bytes.
        buf_mem[(rd_ptr + 0) % 64] = 8'h12;
        buf_mem[(rd_ptr + 1) % 64] = 8'h34;
        buf_mem[(rd_ptr + 2) % 64] = 8'hA5;
        exp_gets4 = 3;
        push_model(8'hC3, 1, 3);
        send(0, 3'd1, 7'd3);
        wait_done(0, 1500);

        // NAK and STALL handshakes.
        exp_gets4 = 0;
        push_model(8'h5A, 0, 0);
        send(0, 3'd4, 7'd5);
        wait_done(0, 400);
        push_model(8'h1E, 0, 0);
        send(0, 3'd5, 7'd0);
        wait_done(0, 400);

        // Invalid codes 0 and 7: a one-cycle error pulse, and the bus stays at J.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tx_packet = (c == 0) ? 3'd0 : 3'd7;
            start4 = 1'b1;
            @(posedge clk); #1;
            check("err_pulse", err4, 1'b1);
            check("err_idle", {dp4, dm4, act4}, 3'b100);
            @(negedge clk);
            start4 = 1'b0;
            @(posedge clk); #1;
            check("err_one_cycle", err4, 1'b0);
        end

        // The same ACK at 8 clocks per bit on the second instance.
        push_ack_table(1);
        send(1, 3'd3, 7'd0);
        wait_done(1, 800);

        // Reset in the middle of a DATA field, then a fresh ACK.
        mon_off4 = 1'b1;
        buf_mem[(rd_ptr + 0) % 64] = 8'h00;
        buf_mem[(rd_ptr + 1) % 64] = 8'h55;
        buf_mem[(rd_ptr + 2) % 64] = 8'hF0;
        send(0, 3'd1, 7'd3);
        repeat (120) @(negedge clk);
        check("pre_rst_active", act4, 1'b1);
        rst = 1'b1;
        q4.delete();
        #1;
        check("midrst_bus", {dp4, dm4}, J);
        check("midrst_act", act4, 1'b0);
        check("midrst_get", get4, 1'b0);
        check("midrst_err", err4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mon_off4 = 1'b0;
        repeat (2) @(negedge clk);
        exp_gets4 = 0;
        push_ack_table(0);
        send(0, 3'd3, 7'd0);
        wait_done(0, 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
